glift_cmp_result_stage: RTL

//  Registered output stage that consumes the six outputs of the 4-bit GLIFT comparator
//  (less/equal/greater plus their taint bits) and buffers them in a 2-entry FIFO with a

---
 rtl/glift_cmp_result_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/glift_cmp_result_stage.sv
// glift_cmp_result_stage
//
// Registered output stage for the 4-bit GLIFT comparator. Each comparator
// result {less,equal,greater} and its taint bits {less_t,equal_t,greater_t}
// is buffered in a 2-entry FIFO and handed to the downstream sink over a
// valid/ready handshake. A saturating counter tracks how many accepted
// results carried any taint, and an alarm flag is raised once that count
// reaches ALARM_THRESH.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_valid/less..greater_t may be asserted at any time and are
// only consumed when in_ready=1. out_* hold stable while out_valid=1 and
// out_ready=0. in_ready is registered and never depends on out_ready.
//
// Optional feature macro: GLIFT_ONEHOT_CHECK_EN
//   defined   -> onehot_err is a sticky flag set when an untainted result is
//                pushed whose {less,equal,greater} is not exactly one-hot.
//   undefined -> onehot_err is tied to 0.
//
// Parameters
//   CNT_W         width of taint_cnt
//   ALARM_THRESH  taint_cnt value at or above which alarm asserts (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (drops all held entries)
//   in_valid     comparator result valid
//   in_ready     stage can accept a result this cycle
//   less/equal/greater, less_t/equal_t/greater_t   comparator result + taint
//   out_valid    head entry valid
//   out_ready    sink accepts head entry
//   out_res      head {less,equal,greater}
//   out_res_t    head {less_t,equal_t,greater_t}
//   out_trusted  head has no taint bit set (0 when out_valid=0)
//   taint_cnt    saturating count of accepted tainted results
//   alarm        registered taint_cnt >= ALARM_THRESH
//   clr_cnt      clear taint_cnt and alarm (wins over a same-cycle increment)
//   onehot_err   sticky one-hot violation flag (see macro above)

module glift_cmp_result_stage #(
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    input  logic             less_t,
    input  logic             equal_t,
    input  logic             greater_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_res,
    output logic [2:0]       out_res_t,
    output logic             out_trusted,
    output logic [CNT_W-1:0] taint_cnt,
    output logic             alarm,
    input  logic             clr_cnt,
    output logic             onehot_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);

    // Entry layout: {res[2:0], res_t[2:0]}; ent0 is always the head.
    logic [5:0]       ent0_q, ent0_d;
    logic [5:0]       ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alarm_q, alarm_d;

    logic [5:0] in_word;
    logic       in_tainted;
    logic       push;
    logic       pop;

    assign in_word    = {less, equal, greater, less_t, equal_t, greater_t};
    assign in_tainted = less_t | equal_t | greater_t;
    assign push       = in_valid & in_ready_q;
    assign pop        = (occ_q != 2'd0) & out_ready;

    // FIFO next state. push&pop together can only happen at occupancy 1:
    // at 0 there is nothing to pop, at 2 in_ready is low. The tail slot is
    // cleared whenever it is vacated so an empty FIFO always shows zeros.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (push && pop) begin
            ent0_d = in_word;
        end else if (push) begin
            if (occ_q == 2'd0) begin
                ent0_d = in_word;
            end else begin
                ent1_d = in_word;
            end
            occ_d = occ_q + 2'd1;
        end else if (pop) begin
            ent0_d = ent1_q;
            ent1_d = '0;
            occ_d  = occ_q - 2'd1;
        end
        in_ready_d = (occ_d != 2'd2);
    end

    // Taint counter: clear wins, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (push && in_tainted && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Evaluated on the next-state count so alarm tracks taint_cnt
        // in the same cycle.
        alarm_d = (cnt_d >= THRESH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            alarm_q    <= 1'b0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            alarm_q    <= alarm_d;
        end
    end

`ifdef GLIFT_ONEHOT_CHECK_EN
    logic onehot_err_q, onehot_err_d;
    logic in_onehot;

    assign in_onehot = (in_word[5:3] == 3'b100) || (in_word[5:3] == 3'b010) ||
                       (in_word[5:3] == 3'b001);

    // Tainted results are exempt: their values are not trustworthy anyway.
    always_comb begin
        onehot_err_d = onehot_err_q;
        if (push && !in_tainted && !in_onehot) begin
            onehot_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err_q <= 1'b0;
        end else begin
            onehot_err_q <= onehot_err_d;
        end
    end

    assign onehot_err = onehot_err_q;
`else
    assign onehot_err = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = (occ_q != 2'd0);
    assign out_res     = ent0_q[5:3];
    assign out_res_t   = ent0_q[2:0];
    assign out_trusted = out_valid & (ent0_q[2:0] == 3'b000);
    assign taint_cnt   = cnt_q;
    assign alarm       = alarm_q;

endmodule
